// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed 32-bit data memory behind a simple req/ack handshake.
//   The memory accepts one request, waits WAIT cycles, then completes it
//   with a single-cycle ack. Each write has per-byte enables. Misaligned
//   addresses and out-of-range addresses complete with err set and no
//   side effect.
//
// Parameters
//   DEPTH  number of 32-bit words (power of two, 4..4096)
//   WAIT   wait cycles between accept and RESP (0..15)
//
// Ports
//   clk    system clock, rising edge
//   reset  synchronous active-low reset
//   req    request valid (sampled only in IDLE)
//   we     1 = write, 0 = read
//   addr   byte address
//   wdata  write data
//   be     byte enables, be[i] -> wdata[8i+7:8i]
//   rdata  read data, valid while ack
//   ack    one-cycle completion pulse
//   err    error flag, valid while ack
//   busy   high whenever the FSM is not IDLE
module data_mem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          addr_bad;
  logic          accept;
  logic          do_write;

  assign idx      = lat_addr[AW+1:2];
  // Misaligned, or any address bit above the word-index range set.
  assign addr_bad = (lat_addr[1:0] != 2'b00) || (lat_addr[31:AW+2] != '0);
  assign accept   = (state == S_IDLE) && req;
  // The write commits on the edge that ends RESP, so reset held low on
  // that edge cancels it.
  assign do_write = reset && (state == S_RESP) && lat_we && !addr_bad;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = (WAIT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch and wait counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      cnt       <= 4'(WAIT);
      lat_we    <= we;
      lat_addr  <= addr;
      lat_wdata <= wdata;
      lat_be    <= be;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Memory array: deliberately not reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

  // Outputs. The response is qualified by reset so that a reset arriving
  // during RESP suppresses the ack instead of letting it through.
  always_comb begin
    ack   = 1'b0;
    err   = 1'b0;
    rdata = '0;
    busy  = (state != S_IDLE);
    if ((state == S_RESP) && reset) begin
      ack = 1'b1;
      err = addr_bad;
      if (!addr_bad && !lat_we) begin
        rdata = mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  logic        q_req;
  logic        q_we;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;
  logic [3:0]  q_be;
  logic [31:0] q_rdata;
  logic        q_ack;
  logic        q_err;
  logic        q_busy;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH(256), .WAIT(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  data_mem_responder #(.DEPTH(256), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(q_req), .we(q_we), .addr(q_addr),
    .wdata(q_wdata), .be(q_be), .rdata(q_rdata), .ack(q_ack), .err(q_err),
    .busy(q_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) until the WAIT=2 instance is back in IDLE, at a negedge.
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_timeout busy=%b required=0", nm, busy);
    end
  endtask

  // One transaction on the WAIT=2 instance. Inputs are scrambled after
  // the accept edge to show the latched request is what completes.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp_rd,
                     input bit exp_err, input string nm);
    int lat;
    bit got;
    wait_idle(nm);
    reset = 1'b1;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        req = 1'b0; we = ~w; addr = 32'h0000_0004; wdata = ~d; be = ~b;
      end
      if (ack === 1'b1) begin
        got = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) begin
          failures++;
          $display("FAIL %s wait_outputs busy=%b rdata=%h err=%b required busy=1 rdata=0 err=0",
                   nm, busy, rdata, err);
        end
      end
    end
    checks++;
    if (!got || lat != 3) begin
      failures++;
      $display("FAIL %s latency got_ack=%b cycles=%0d required=3", nm, got, lat);
    end
    checks++;
    if (rdata !== exp_rd || err !== exp_err) begin
      failures++;
      $display("FAIL %s response rdata=%h err=%b required rdata=%h err=%b",
               nm, rdata, err, exp_rd, exp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    q_req = 1'b0; q_we = 1'b0; q_addr = '0; q_wdata = '0; q_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ack=%b err=%b rdata=%h busy=%b required all 0",
               ack, err, rdata, busy);
    end
    checks++;
    if (q_ack !== 1'b0 || q_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_w0 ack=%b busy=%b required 0 0", q_ack, q_busy);
    end
  endtask

  // First request is presented in the same cycle reset is released.
  task automatic test_write_read();
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "write_10");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "read_10");
  endtask

  task automatic test_byte_enable();
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0, "write_be0101");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, "read_be0101");
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, "write_be0000");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, "read_be0000");
  endtask

  task automatic test_errors();
    txn(1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0, "write_0");
    txn(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, "read_misaligned");
    txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "write_oob");
    txn(1'b1, 32'h3FE, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "write_misaligned");
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'h01020304, 1'b0, "read_0_after_err");
    txn(1'b1, 32'h3FC, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0, "write_last");
    txn(1'b0, 32'h3FC, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, "read_last");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int nacks;
    int idle_between;
    int t [3];
    wait_idle("b2b");
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = '0; be = '0;
    cyc = 0; nacks = 0; idle_between = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    while (nacks < 3 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (nacks == 1 && busy === 1'b0) idle_between++;
      if (ack === 1'b1) begin
        t[nacks] = cyc;
        checks++;
        if (rdata !== 32'hDE22BE44 || err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_data%0d rdata=%h err=%b required rdata=de22be44 err=0",
                   nacks, rdata, err);
        end
        nacks++;
        if (nacks == 3) req = 1'b0;
      end
    end
    checks++;
    if (nacks != 3 || t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
      failures++;
      $display("FAIL b2b_spacing acks=%0d gaps=%0d,%0d required 3 acks gaps 4,4",
               nacks, t[1] - t[0], t[2] - t[1]);
    end
    checks++;
    if (idle_between != 1) begin
      failures++;
      $display("FAIL b2b_idle busy_low_cycles=%0d required=1", idle_between);
    end
  endtask

  task automatic test_reset_midop();
    txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "pre_write_20");
    wait_idle("midop");
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0BADBEEF; be = 4'hF;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL midop_in_resp ack=%b required=1", ack);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL midop_suppressed ack=%b err=%b rdata=%h required 0 0 0",
               ack, err, rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      failures++;
      $display("FAIL midop_idle busy=%b ack=%b required 0 0", busy, ack);
    end
    @(negedge clk);
    reset = 1'b1;
    txn(1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "midop_mem_unchanged");
  endtask

  task automatic test_wait0();
    @(negedge clk);
    q_req = 1'b1; q_we = 1'b1; q_addr = 32'h8; q_wdata = 32'h12345678; q_be = 4'hF;
    @(posedge clk); #1;
    q_req = 1'b0; q_wdata = '0;
    checks++;
    if (q_ack !== 1'b1 || q_err !== 1'b0 || q_rdata !== 32'h0) begin
      failures++;
      $display("FAIL w0_write ack=%b err=%b rdata=%h required 1 0 0", q_ack, q_err, q_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    q_req = 1'b1; q_we = 1'b0; q_addr = 32'h8;
    @(posedge clk); #1;
    q_req = 1'b0; q_addr = '0;
    checks++;
    if (q_ack !== 1'b1 || q_rdata !== 32'h12345678 || q_err !== 1'b0) begin
      failures++;
      $display("FAIL w0_read ack=%b rdata=%h err=%b required 1 12345678 0",
               q_ack, q_rdata, q_err);
    end
    @(posedge clk); #1;
    checks++;
    if (q_ack !== 1'b0 || q_busy !== 1'b0) begin
      failures++;
      $display("FAIL w0_after ack=%b busy=%b required 0 0", q_ack, q_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    test_wait0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have the parameter DEPTH, default 256, meaning the number of 32-bit memory words (power of two, 4..4096).
REQ-002 The module SHALL have the parameter WAIT, default 2, meaning the number of wait cycles between accepting a request and acknowledging it (0..15).
REQ-003 The module SHALL have the port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have the port reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets).
REQ-005 The module SHALL have the port req  input  1  processor memory request valid.
REQ-006 The module SHALL have the port we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 The module SHALL have the port addr  input  32  byte address.
REQ-008 The module SHALL have the port wdata  input  32  write data.
REQ-009 The module SHALL have the port be  input  4  byte enables for writes; be[i] enables wdata[8i+7:8i].
REQ-010 The module SHALL have the port rdata  output  32  read data, valid while ack==1.
REQ-011 The module SHALL have the port ack  output  1  one-cycle completion pulse.
REQ-012 The module SHALL have the port err  output  1  error flag, valid while ack==1.
REQ-013 The module SHALL have the port busy  output  1  1 whenever state is not IDLE.

Function
REQ-014 The module SHALL implement the FSM states IDLE, WAIT, and RESP.
REQ-015 In IDLE with req==1, the module SHALL latch we, addr, wdata, and be, load the wait counter with WAIT, and go to WAIT (or directly to RESP when WAIT==0).
REQ-016 In IDLE with req==0, the module SHALL remain in IDLE.
REQ-017 In WAIT, the module SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 1; total latency from accept edge to ack SHALL be WAIT+1 cycles.
REQ-018 In RESP, the module SHALL drive ack=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-019 Inputs SHALL be ignored after acceptance; changes to req, addr, or data during WAIT or RESP SHALL have no effect on the transaction in flight.
REQ-020 A request still held high in the IDLE cycle following RESP SHALL be accepted as a new transaction, so back-to-back throughput is one transaction per WAIT+2 cycles.
REQ-021 The word index SHALL be latched addr[log2(DEPTH)+1:2].
REQ-022 Error: if latched addr[1:0]!=0 or latched addr >= 4*DEPTH, then in RESP the module SHALL drive err=1 and rdata=0, and SHALL NOT modify memory.
REQ-023 Read without error: in RESP, rdata SHALL equal the memory word at the index; err SHALL be 0.
REQ-024 Write without error: the memory SHALL be updated in the RESP cycle, only for enabled bytes; rdata SHALL be 0 and err SHALL be 0.
REQ-025 A write with be==4'b0000 SHALL complete normally with ack, leaving memory unchanged.
REQ-026 Outside RESP, ack SHALL be 0, err SHALL be 0, and rdata SHALL be 0.
REQ-027 A read issued after a write to the same word SHALL return the written value (no stale data).

Reset
REQ-028 While reset==0 at a clk edge, the module SHALL set state to IDLE, the counter to 0, ack, err, and busy to 0, rdata to 0, and clear the latched request.
REQ-029 Reset asserted during WAIT or RESP SHALL abort the transaction; no ack SHALL be issued and no memory write SHALL occur if reset coincides with the RESP edge.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 The first request SHALL be accepted on the first edge with reset==1 and req==1.

Verification
REQ-032 Write then read: write addr=0x10, wdata=0xDEADBEEF, be=4'hF; then read 0x10 -> ack 3 cycles after each accept (WAIT=2), read rdata=0xDEADBEEF, err=0.
REQ-033 Byte enables: after 0xDEADBEEF at 0x10, write wdata=0x11223344, be=4'b0101 -> read 0x10 returns 0xDE22BE44.
REQ-034 Errors: read addr=0x13 -> ack with err=1 and rdata=0; write addr=0x400 (DEPTH=256) -> err=1, and a following read of 0x0 is unchanged.
REQ-035 Back-to-back: req held high for 3 reads -> ack pulses spaced exactly WAIT+2=4 cycles apart, busy low for exactly one cycle between transactions.
REQ-036 Reset mid-op: a write is accepted and reset==0 is applied in the RESP cycle -> no ack, memory unchanged, outputs 0, state IDLE.
REQ-037 WAIT=0 build: a read is accepted -> ack on the next cycle (latency 1).
